// File: rtl/cplx_dot_acc.sv
// rtl/cplx_dot_acc.sv - complex dot-product accumulator for a fixed number of beats
//
// Sums LEN signed complex products (in_re + j*in_im) into ACC_W-bit real and
// imaginary accumulators. The result is held until the downstream accepts it.
//
// Optional feature: define CPLX_DOT_ACC_SAT_EN to clamp overflowing components
// instead of wrapping them.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous abort of the partial sum (ignored while a result is held)
//   in_valid   input beat valid
//   in_ready   block can accept a beat
//   in_re      signed real part of the incoming product (DATA_W bits)
//   in_im      signed imaginary part of the incoming product (DATA_W bits)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_re     signed accumulated real part (ACC_W bits)
//   out_im     signed accumulated imaginary part (ACC_W bits)
//   ovf        sticky overflow flag for the current result
module cplx_dot_acc #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 20,
  parameter int LEN    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_re,
  output logic signed [ACC_W-1:0]  out_im,
  output logic                     ovf
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         count, count_nxt;
  logic signed [ACC_W-1:0]  sum_re, sum_re_nxt;
  logic signed [ACC_W-1:0]  sum_im, sum_im_nxt;
  logic                     ovf_q, ovf_nxt;

  logic                     beat;
  logic signed [ACC_W-1:0]  add_re, add_im;
  logic                     ovf_re, ovf_im;

  // Returns {overflow, result}. Overflow is detected when both operands share
  // a sign and the wrapped sum does not.
  function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W-1:0] s;
    logic                    o;
    s = a + b;
    o = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
`ifdef CPLX_DOT_ACC_SAT_EN
    if (o) begin
      s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
    return {o, s};
  endfunction

  assign {ovf_re, add_re} = acc_add(sum_re, ACC_W'(in_re));
  assign {ovf_im, add_im} = acc_add(sum_im, ACC_W'(in_im));

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign out_re    = sum_re;
  assign out_im    = sum_im;
  assign ovf       = ovf_q;

  // clr wins over a beat presented in the same cycle
  assign beat = in_valid && in_ready && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      sum_re <= '0;
      sum_im <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      sum_re <= sum_re_nxt;
      sum_im <= sum_im_nxt;
      ovf_q  <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    sum_re_nxt = sum_re;
    sum_im_nxt = sum_im;
    ovf_nxt    = ovf_q;
    case (state)
      IDLE, ACC: begin
        if (clr) begin
          state_nxt  = IDLE;
          count_nxt  = '0;
          sum_re_nxt = '0;
          sum_im_nxt = '0;
          ovf_nxt    = 1'b0;
        end else if (beat) begin
          sum_re_nxt = add_re;
          sum_im_nxt = add_im;
          ovf_nxt    = ovf_q | ovf_re | ovf_im;
          // The LEN-th beat completes the result; with LEN=1 this fires from IDLE.
          if (count == CNT_W'(LEN - 1)) begin
            state_nxt = DONE;
            count_nxt = '0;
          end else begin
            state_nxt = ACC;
            count_nxt = count + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt  = IDLE;
          sum_re_nxt = '0;
          sum_im_nxt = '0;
          ovf_nxt    = 1'b0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        count_nxt  = '0;
        sum_re_nxt = '0;
        sum_im_nxt = '0;
        ovf_nxt    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cplx_dot_acc.sv
// tb/tb_cplx_dot_acc.sv - directed self-checking bench for cplx_dot_acc
module tb_cplx_dot_acc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance a: default parameters
  logic               a_clr, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
  logic signed [15:0] a_in_re, a_in_im;
  logic signed [19:0] a_out_re, a_out_im;

  // instance b: ACC_W=16
  logic               b_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
  logic signed [15:0] b_in_re, b_in_im;
  logic [15:0]        b_out_re, b_out_im;

  // instance c: LEN=1
  logic               c_clr, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_ovf;
  logic signed [15:0] c_in_re, c_in_im;
  logic signed [19:0] c_out_re, c_out_im;

  cplx_dot_acc dut_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_re(a_in_re), .in_im(a_in_im), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_re(a_out_re), .out_im(a_out_im), .ovf(a_ovf)
  );

  cplx_dot_acc #(.DATA_W(16), .ACC_W(16), .LEN(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_re(b_in_re), .in_im(b_in_im), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_re(b_out_re), .out_im(b_out_im), .ovf(b_ovf)
  );

  cplx_dot_acc #(.DATA_W(16), .ACC_W(20), .LEN(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_re(c_in_re), .in_im(c_in_im), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_re(c_out_re), .out_im(c_out_im), .ovf(c_ovf)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic a_beat(input logic signed [15:0] re, input logic signed [15:0] im);
    a_in_valid = 1'b1;
    a_in_re    = re;
    a_in_im    = im;
    step();
  endtask

  task automatic b_beat(input logic signed [15:0] re, input logic signed [15:0] im);
    b_in_valid = 1'b1;
    b_in_re    = re;
    b_in_im    = im;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    a_clr = 1'b0; a_in_valid = 1'b0; a_in_re = '0; a_in_im = '0; a_out_ready = 1'b0;
    b_clr = 1'b0; b_in_valid = 1'b0; b_in_re = '0; b_in_im = '0; b_out_ready = 1'b0;
    c_clr = 1'b0; c_in_valid = 1'b0; c_in_re = '0; c_in_im = '0; c_out_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_re", $signed(a_out_re), 0);
    check("rst_out_im", $signed(a_out_im), 0);
    check("rst_ovf", a_ovf, 0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", a_in_ready, 1);

    // basic two-beat result
    a_out_ready = 1'b1;
    a_beat(-16'sd7, 16'sd22);
    check("basic_mid_valid", a_out_valid, 0);
    check("basic_mid_ready", a_in_ready, 1);
    a_beat(16'sd0, 16'sd2);
    a_in_valid = 1'b0;
    check("basic_valid", a_out_valid, 1);
    check("basic_re", $signed(a_out_re), -7);
    check("basic_im", $signed(a_out_im), 24);
    check("basic_ovf", a_ovf, 0);
    step();
    check("basic_after_valid", a_out_valid, 0);
    check("basic_after_ready", a_in_ready, 1);

    // hold in DONE with backpressure; clr and a pending beat must not disturb it
    a_out_ready = 1'b0;
    a_beat(16'sd1, 16'sd1);
    a_beat(16'sd2, 16'sd2);
    a_in_re = 16'sd7;
    a_in_im = 16'sd7;
    for (int i = 0; i < 5; i++) begin
      check("hold_in_ready", a_in_ready, 0);
      check("hold_valid", a_out_valid, 1);
      check("hold_re", $signed(a_out_re), 3);
      check("hold_im", $signed(a_out_im), 3);
      a_clr = (i == 2);
      step();
    end
    a_clr       = 1'b0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    step();
    check("hold_release_valid", a_out_valid, 0);
    check("hold_release_ready", a_in_ready, 1);
    check("hold_release_re", $signed(a_out_re), 0);

    // clr mid-accumulation discards partial sum and the concurrent beat
    a_beat(16'sd5, 16'sd5);
    check("clr_pre_re", $signed(a_out_re), 5);
    a_clr = 1'b1;
    a_beat(16'sd9, 16'sd9);
    a_clr = 1'b0;
    check("clr_re", $signed(a_out_re), 0);
    check("clr_im", $signed(a_out_im), 0);
    check("clr_valid", a_out_valid, 0);
    a_beat(16'sd1, 16'sd1);
    check("clr_one_beat_valid", a_out_valid, 0);
    a_beat(16'sd2, 16'sd2);
    a_in_valid = 1'b0;
    check("clr_res_valid", a_out_valid, 1);
    check("clr_res_re", $signed(a_out_re), 3);
    check("clr_res_im", $signed(a_out_im), 3);
    step();

    // asynchronous reset mid-ACC
    a_beat(16'sd4, 16'sd4);
    a_in_valid = 1'b0;
    check("arst_pre_re", $signed(a_out_re), 4);
    #1 rst_n = 1'b0;
    #1;
    check("arst_acc_re", $signed(a_out_re), 0);
    check("arst_acc_im", $signed(a_out_im), 0);
    check("arst_acc_valid", a_out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // asynchronous reset in DONE
    a_out_ready = 1'b0;
    a_beat(16'sd1, 16'sd1);
    a_beat(16'sd2, 16'sd2);
    a_in_valid = 1'b0;
    check("arst_done_pre_valid", a_out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_done_valid", a_out_valid, 0);
    check("arst_done_re", $signed(a_out_re), 0);
    check("arst_done_ovf", a_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    step();
    check("arst_resume_ready", a_in_ready, 1);
    a_beat(16'sd10, -16'sd3);
    a_beat(16'sd20, -16'sd4);
    a_in_valid = 1'b0;
    check("arst_resume_valid", a_out_valid, 1);
    check("arst_resume_re", $signed(a_out_re), 30);
    check("arst_resume_im", $signed(a_out_im), -7);
    step();

    // overflow with ACC_W=16
    b_out_ready = 1'b1;
    b_beat(16'sh7FFF, 16'sd0);
    b_beat(16'sd1, 16'sd0);
    b_in_valid = 1'b0;
    check("ovf_pos_valid", b_out_valid, 1);
`ifdef CPLX_DOT_ACC_SAT_EN
    check("ovf_pos_re", b_out_re, 32'h7FFF);
`else
    check("ovf_pos_re", b_out_re, 32'h8000);
`endif
    check("ovf_pos_flag", b_ovf, 1);
    step();
    check("ovf_clear", b_ovf, 0);
    b_beat(16'sd0, -16'sd32768);
    b_beat(16'sd0, -16'sd1);
    b_in_valid = 1'b0;
`ifdef CPLX_DOT_ACC_SAT_EN
    check("ovf_neg_im", b_out_im, 32'h8000);
`else
    check("ovf_neg_im", b_out_im, 32'h7FFF);
`endif
    check("ovf_neg_re", b_out_re, 32'h0000);
    check("ovf_neg_flag", b_ovf, 1);
    step();

    // LEN=1 with continuous valid: one result every two cycles
    c_out_ready = 1'b1;
    c_in_valid  = 1'b1;
    c_in_re     = 16'sd1;
    c_in_im     = 16'sd1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("len1_valid", c_out_valid, 1);
      check("len1_re", $signed(c_out_re), k);
      check("len1_im", $signed(c_out_im), k);
      check("len1_busy", c_in_ready, 0);
      c_in_re = 16'(k + 1);
      c_in_im = 16'(k + 1);
      if (k == 3) c_in_valid = 1'b0;
      step();
      check("len1_gap_valid", c_out_valid, 0);
      check("len1_gap_ready", c_in_ready, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
